// File: rtl/genie_elastic_fifo_pkg.sv
// ----------------------------------------------------------------------------
// genie_elastic_fifo_pkg
//
// Purpose:
//   Shared helpers for the genie_elastic_fifo block. Pointer and level widths
//   depend on the DEPTH parameter of each instance, so they are derived
//   locally in the modules. This package only carries parameter-independent
//   constants and the elaboration-time helper used to check DEPTH.
//
// Contents:
//   DEFAULT_WIDTH / DEFAULT_DEPTH - default payload width and entry count
//   is_pow2()                     - true when the argument is a positive power of two
// ----------------------------------------------------------------------------
package genie_elastic_fifo_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // Evaluated at elaboration time only. Pointers wrap naturally at their
    // bit width, which is correct only when DEPTH is a power of two.
    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage : genie_elastic_fifo_pkg

// File: rtl/genie_elastic_fifo_mem.sv
// ----------------------------------------------------------------------------
// genie_elastic_fifo_mem
//
// Purpose:
//   Register array for the elastic FIFO. It has one synchronous write port
//   and one asynchronous (combinational) read port. The asynchronous read
//   lets the FIFO present the head word in the same cycle the read pointer
//   points at it (show-ahead).
//
// Ports:
//   clk    in   rising-edge clock for the write port
//   we     in   write enable; when high, wdata is stored at waddr
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  contents of entry raddr (combinational)
// ----------------------------------------------------------------------------
module genie_elastic_fifo_mem #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] regs [DEPTH];

    // NOTE: the array has no reset. The pointers and the level decide which
    // entries are meaningful, so the stale contents are never observed.
    // Leaving the array unreset keeps it a plain register file and avoids
    // a reset fan-out to every storage bit.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always assigned with <=. This way every
        // reader in the same time step sees the value from before the edge,
        // whatever order the always blocks run in.
        if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata = regs[raddr];

endmodule : genie_elastic_fifo_mem

// File: rtl/genie_elastic_fifo.sv
// ----------------------------------------------------------------------------
// genie_elastic_fifo
//
// Purpose:
//   Elastic buffer placed directly after the fixed-latency memory delay
//   stage. It absorbs the delayed stream while the consumer stalls, and it
//   keeps the consumer's ready signal off the delay pipeline's enable path:
//   o_ready depends only on registered state and reset.
//   The design is a show-ahead register ring buffer with valid/ready on
//   both sides, an occupancy count and an almost-full flag.
//
// Parameters:
//   WIDTH      payload width in bits
//   DEPTH      number of entries (power of two, >= 2)
//   AF_THRESH  o_almost_full asserts when the level is >= this value (1..DEPTH)
//
// Ports:
//   clk            in   single clock, rising edge
//   reset          in   synchronous, active-high reset
//   i_data         in   upstream payload
//   i_valid        in   upstream payload valid
//   o_ready        out  FIFO can accept i_data this cycle
//   o_data         out  head-of-queue payload (don't-care when !o_valid)
//   o_valid        out  o_data valid
//   i_ready        in   downstream accepts o_data this cycle
//   o_level        out  current occupancy
//   o_almost_full  out  o_level >= AF_THRESH
// ----------------------------------------------------------------------------
module genie_elastic_fifo
    import genie_elastic_fifo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int AF_THRESH = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_valid,
    output logic                       o_ready,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH+1)-1:0] o_level,
    output logic                       o_almost_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(AF_THRESH);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("genie_elastic_fifo: DEPTH must be a power of two and >= 2");
    end

    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af_thresh
        $error("genie_elastic_fifo: AF_THRESH must lie in 1..DEPTH");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] wrptr;
    logic [PTR_W-1:0] rdptr;
    logic [LVL_W-1:0] level;

    logic push;
    logic pop;

    // o_ready uses only registered level and reset. Because i_ready does not
    // appear here, a full FIFO refuses a word even in a cycle where it pops.
    // The freed slot becomes visible one cycle later.
    assign o_ready = !reset && (level != LVL_FULL);
    assign o_valid = !reset && (level != '0);

    assign push = i_valid && o_ready;
    assign pop  = o_valid && i_ready;

    // Gated by reset so that the outputs read as empty while reset is high,
    // including the first reset cycle before the registers have cleared.
    assign o_level       = reset ? '0 : level;
    assign o_almost_full = !reset && (level >= LVL_AF);

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wrptr <= '0;
            rdptr <= '0;
            level <= '0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits wide, so +1 wraps
            // from DEPTH-1 to 0 with no compare.
            if (push) begin
                wrptr <= wrptr + 1'b1;
            end
            if (pop) begin
                rdptr <= rdptr + 1'b1;
            end
            // Push and pop in the same cycle cancel each other.
            if (push && !pop) begin
                level <= level + LVL_ONE;
            end else if (pop && !push) begin
                level <= level - LVL_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    genie_elastic_fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wrptr),
        .wdata (i_data),
        .raddr (rdptr),
        .rdata (o_data)
    );

    // ------------------------------------------------------------------
    // Simulation-only protocol checks
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && level == LVL_FULL))
                else $error("genie_elastic_fifo: push while full");
            assert (!(pop && level == '0))
                else $error("genie_elastic_fifo: pop while empty");
        end
    end

endmodule : genie_elastic_fifo

// File: tb/tb_genie_elastic_fifo.sv
// ----------------------------------------------------------------------------
// tb_genie_elastic_fifo
//
// Directed testbench for genie_elastic_fifo (WIDTH=8, DEPTH=4, AF_THRESH=3).
// Inputs are driven 1 time unit after a rising edge. Outputs are sampled
// 2 units later, mid-cycle and away from any edge. Every expected value is
// a hand-computed constant taken from the FIFO's documented behaviour.
// ----------------------------------------------------------------------------
module tb_genie_elastic_fifo;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 4;
    localparam int AF_THRESH = 3;
    localparam int LVL_W     = $clog2(DEPTH + 1);

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] i_data;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] o_data;
    logic             o_valid;
    logic             i_ready;
    logic [LVL_W-1:0] o_level;
    logic             o_almost_full;

    int tests_run;
    int tests_failed;

    genie_elastic_fifo #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_data        (i_data),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_level       (o_level),
        .o_almost_full (o_almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 unit after the next rising edge, where inputs change.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
            else begin
                tests_failed++;
                $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
            end
    endtask

    // Global watchdog: the directed sequence is a few hundred cycles at most.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset   = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        i_ready = 1'b0;

        // ---------------- Reset ----------------
        tick();
        settle();
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd0);
        check("rst_level", 32'(o_level), 32'd0);
        check("rst_af",    32'(o_almost_full), 32'd0);
        tick();
        reset = 1'b0;
        settle();
        check("post_rst_ready", 32'(o_ready), 32'd1);
        check("post_rst_valid", 32'(o_valid), 32'd0);
        check("post_rst_level", 32'(o_level), 32'd0);

        // ---------------- Push into empty with i_ready=1 ----------------
        i_valid = 1'b1;
        i_data  = 8'h11;
        i_ready = 1'b1;
        settle();
        check("empty_no_fallthru", 32'(o_valid), 32'd0);
        tick();
        i_valid = 1'b0;
        settle();
        check("one_valid", 32'(o_valid), 32'd1);
        check("one_data",  32'(o_data),  32'h11);
        check("one_level", 32'(o_level), 32'd1);
        tick();
        settle();
        check("one_drained_level", 32'(o_level), 32'd0);
        check("one_drained_valid", 32'(o_valid), 32'd0);

        // ---------------- Fill to full with i_ready=0 ----------------
        i_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_valid = 1'b1;
            i_data  = 8'hA0 + 8'(k);
            settle();
            check("fill_ready", 32'(o_ready), 32'd1);
            check("fill_level", 32'(o_level), 32'(k));
            check("fill_af",    32'(o_almost_full), (k >= 3) ? 32'd1 : 32'd0);
            tick();
        end
        i_data = 8'hA4;
        settle();
        check("full_level", 32'(o_level), 32'd4);
        check("full_af",    32'(o_almost_full), 32'd1);
        check("full_ready", 32'(o_ready), 32'd0);
        tick();
        settle();
        check("full_reject_level", 32'(o_level), 32'd4);
        check("full_head",         32'(o_data),  32'hA0);

        // ---------------- Pop while full, offered word not accepted ------
        i_data  = 8'hB0;
        i_ready = 1'b1;
        settle();
        check("full_pop_ready", 32'(o_ready), 32'd0);
        check("full_pop_data",  32'(o_data),  32'hA0);
        tick();
        i_ready = 1'b0;
        settle();
        check("after_pop_level", 32'(o_level), 32'd3);
        check("after_pop_ready", 32'(o_ready), 32'd1);
        check("after_pop_head",  32'(o_data),  32'hA1);
        tick();
        i_valid = 1'b0;
        settle();
        check("b0_in_level", 32'(o_level), 32'd4);
        check("b0_in_head",  32'(o_data),  32'hA1);

        // Drain: A1, A2, A3, B0
        i_ready = 1'b1;
        check("drain0", 32'(o_data), 32'hA1);
        tick(); settle();
        check("drain1", 32'(o_data), 32'hA2);
        tick(); settle();
        check("drain2", 32'(o_data), 32'hA3);
        tick(); settle();
        check("drain3", 32'(o_data), 32'hB0);
        check("drain3_valid", 32'(o_valid), 32'd1);
        tick(); settle();
        check("drained_valid", 32'(o_valid), 32'd0);
        check("drained_level", 32'(o_level), 32'd0);

        // ---------------- Streaming with one primer word ----------------
        i_valid = 1'b1;
        i_data  = 8'hEE;
        tick();
        for (int i = 0; i < 20; i++) begin
            i_data = 8'(i);
            settle();
            check("stream_level", 32'(o_level), 32'd1);
            check("stream_data",  32'(o_data),  (i == 0) ? 32'hEE : 32'(i - 1));
            check("stream_ready", 32'(o_ready), 32'd1);
            tick();
        end
        i_valid = 1'b0;
        settle();
        check("stream_tail_data",  32'(o_data),  32'h13);
        check("stream_tail_level", 32'(o_level), 32'd1);
        tick(); settle();
        check("stream_empty_level", 32'(o_level), 32'd0);

        // ---------------- Reset mid-operation ----------------
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 8'hC0;
        tick();
        i_data  = 8'hC1;
        tick();
        i_valid = 1'b0;
        settle();
        check("pre_rst_level", 32'(o_level), 32'd2);
        check("pre_rst_valid", 32'(o_valid), 32'd1);
        check("pre_rst_head",  32'(o_data),  32'hC0);
        reset = 1'b1;
        settle();
        check("mid_rst_valid", 32'(o_valid), 32'd0);
        check("mid_rst_ready", 32'(o_ready), 32'd0);
        check("mid_rst_level", 32'(o_level), 32'd0);
        check("mid_rst_af",    32'(o_almost_full), 32'd0);
        tick();
        reset   = 1'b0;
        i_ready = 1'b1;
        settle();
        check("after_rst_level", 32'(o_level), 32'd0);
        check("after_rst_valid", 32'(o_valid), 32'd0);
        check("after_rst_ready", 32'(o_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick(); settle();
            check("discarded_valid", 32'(o_valid), 32'd0);
        end

        // The FIFO still works after reset and starts from pointer 0.
        i_valid = 1'b1;
        i_data  = 8'hD0;
        tick();
        i_valid = 1'b0;
        settle();
        check("post_rst_push_valid", 32'(o_valid), 32'd1);
        check("post_rst_push_data",  32'(o_data),  32'hD0);
        tick(); settle();
        check("post_rst_push_level", 32'(o_level), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_genie_elastic_fifo

// File: doc/genie_elastic_fifo.md
Name: genie_elastic_fifo

Overview:
- Elastic buffer placed directly downstream of the fixed-latency memory delay stage.
- Absorbs that stage's output when the consumer stalls, and decouples the consumer's ready from the delay pipeline's enable.
- Show-ahead, register-based ring buffer with valid/ready on both sides, occupancy count and almost-full flag.
- Used wherever a delayed stream feeds a consumer with bursty backpressure.

Parameters:
- WIDTH, 8: payload width in bits.
- DEPTH, 4: number of entries; power of two, minimum 2.
- AF_THRESH, DEPTH-1: o_almost_full asserts when level is at or above this value; range 1..DEPTH.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- i_data  input  WIDTH  upstream payload.
- i_valid  input  1  upstream payload valid.
- o_ready  output  1  block can accept i_data this cycle.
- o_data  output  WIDTH  head-of-queue payload.
- o_valid  output  1  o_data valid.
- i_ready  input  1  downstream accepts o_data this cycle.
- o_level  output  $clog2(DEPTH+1)  current occupancy.
- o_almost_full  output  1  o_level >= AF_THRESH.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset), sampled only on the rising edge of clk.
- Signals: push = i_valid && o_ready; pop = o_valid && i_ready.
- Storage: DEPTH x WIDTH register array. Write pointer wrptr and read pointer rdptr are each $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Separate count register level, width $clog2(DEPTH+1).
  - level increments on push only, decrements on pop only, and is unchanged on push && pop or neither.
- o_ready = !reset && (level != DEPTH). Depends only on registered state and reset, never on i_ready; no combinational path from i_ready to o_ready.
- o_valid = (level != 0) && !reset.
- o_data = mem[rdptr]; combinational read of the registered array (show-ahead).
  - o_data is don't-care when o_valid = 0.
  - Must hold stable while o_valid && !i_ready.
- Latency: a word pushed into an empty FIFO at edge N is visible (o_valid = 1) in the cycle after edge N. No fall-through in the same cycle.
- Full: o_ready = 0 even if pop occurs in the same cycle. A pop while full frees one slot, so o_ready rises the next cycle.
- Empty: push && i_ready in the same cycle → no pop, because o_valid is 0. The word appears next cycle.
- Simultaneous push and pop when partially filled: both pointers advance and level is held.
- Write enable is push only. Array contents are never cleared, including on reset.
- Reset (including mid-operation):
  - At the next edge, wrptr = rdptr = 0 and level = 0.
  - Any queued data is discarded.
  - While reset is high, o_ready = 0, o_valid = 0, o_level = 0 and o_almost_full = 0 (AF_THRESH >= 1).
  - In the cycle after reset is deasserted, o_ready = 1 and o_valid = 0.
- o_almost_full is combinational from level.
- Elaboration assertions:
  - DEPTH is a power of two and DEPTH >= 2.
  - 1 <= AF_THRESH <= DEPTH.
- Simulation assertions:
  - No push when level == DEPTH.
  - No pop when level == 0.

Decomposition:
- No shared-package typedefs required; pointer and level widths are local parameters derived from DEPTH.
- One natural sub-module: genie_elastic_fifo_mem, holding the register array with write port (we, waddr, wdata) and asynchronous read port (raddr, rdata).
- Pointers, level and handshake logic stay in the top module.

Test Plan (WIDTH=8, DEPTH=4, AF_THRESH=3):
- Reset → o_valid=0, o_ready=0 during reset, o_ready=1 the cycle after, o_level=0, o_almost_full=0.
- Push 0x11 into empty with i_ready=1 → o_valid=0 that cycle; next cycle o_valid=1, o_data=0x11, pop, then o_level=0.
- i_ready=0, push 0xA0..0xA3 → o_level 1,2,3,4; o_almost_full rises at level 3; o_ready=0 at level 4; a fifth i_valid word 0xA4 is not accepted.
- Full, i_valid=1 with 0xB0, i_ready=1 for one cycle → 0xA0 popped, 0xB0 not accepted, o_level=3; next cycle o_ready=1 and 0xB0 accepted, o_level=4. Drain order: A1, A2, A3, B0.
- Continuous i_valid=1 and i_ready=1 for 20 words 0x00..0x13 after one primer word → o_level constant at 1, output in order, pointers wrap five times with no loss.
- Level 2 (words 0xC0, 0xC1) with o_valid=1 and i_ready=0, assert reset for 1 cycle → after reset o_level=0, o_valid=0, and 0xC0/0xC1 are never emitted.
